// File: rtl/lcd_pkg.sv
// lcd_pkg: shared mode encodings, direction states and bar palette for the LCD pattern generator.
package lcd_pkg;
  typedef enum logic [1:0] {
    LCD_MODE_BARS  = 2'd0,
    LCD_MODE_CHECK = 2'd1,
    LCD_MODE_GRAD  = 2'd2,
    LCD_MODE_SOLID = 2'd3
  } lcd_mode_e;
  typedef enum logic {DIR_POS, DIR_NEG} lcd_dir_e;
  localparam logic [23:0] LCD_PALETTE [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000
  };
endpackage

// File: rtl/lcd_bounce_dot.sv
// lcd_bounce_dot: step-divided bouncing dot position with independent per-axis direction FSMs.
module lcd_bounce_dot import lcd_pkg::*; #(
  parameter int LCD_WIDTH  = 480,
  parameter int LCD_HEIGHT = 280,
  parameter int COORD_W    = 11,
  parameter int DOT_SIZE   = 5,
  parameter int STEP_DIV   = 150000
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               PAUSE,
  output logic [COORD_W-1:0] dot_x,
  output logic [COORD_W-1:0] dot_y
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [COORD_W-1:0] MINX = COORD_W'(DOT_SIZE + 1);
  localparam logic [COORD_W-1:0] MAXX = COORD_W'(LCD_WIDTH - DOT_SIZE - 1);
  localparam logic [COORD_W-1:0] MINY = COORD_W'(DOT_SIZE + 1);
  localparam logic [COORD_W-1:0] MAXY = COORD_W'(LCD_HEIGHT - DOT_SIZE - 1);
  logic [CW-1:0] step_cnt;
  lcd_dir_e dir_x, dir_y;
  logic tick;
  assign tick = step_cnt == CW'(STEP_DIV - 1);
  // A bounce costs one tick: the position holds at the limit while the direction flips.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      step_cnt <= '0;
      dot_x    <= COORD_W'(LCD_WIDTH / 2);
      dot_y    <= COORD_W'(LCD_HEIGHT / 2);
      dir_x    <= DIR_POS;
      dir_y    <= DIR_POS;
    end else if (!PAUSE) begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        if (dir_x == DIR_POS) begin
          if (dot_x == MAXX) dir_x <= DIR_NEG;
          else dot_x <= dot_x + 1'b1;
        end else begin
          if (dot_x == MINX) dir_x <= DIR_POS;
          else dot_x <= dot_x - 1'b1;
        end
        if (dir_y == DIR_POS) begin
          if (dot_y == MAXY) dir_y <= DIR_NEG;
          else dot_y <= dot_y + 1'b1;
        end else begin
          if (dot_y == MINY) dir_y <= DIR_POS;
          else dot_y <= dot_y - 1'b1;
        end
      end
    end
endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: selectable LCD test patterns with frame-latched mode, border/dot overlay and
// a one-cycle registered RGB/DE output stage.
module lcd_pattern_gen import lcd_pkg::*; #(
  parameter int LCD_WIDTH  = 480,
  parameter int LCD_HEIGHT = 280,
  parameter int COORD_W    = 11,
  parameter int DOT_SIZE   = 5,
  parameter int STEP_DIV   = 150000,
  parameter int NUM_BARS   = 3,
  parameter int CHECK_LOG2 = 4,
  parameter int GRAD_SHIFT = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [1:0]         MODE,
  input  logic [23:0]        SOLID_RGB,
  input  logic               FRAME_START,
  input  logic               PAUSE,
  input  logic               OVERLAY_EN,
  input  logic               DEN,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               DE_O
);
  localparam logic [COORD_W:0] DS = (COORD_W + 1)'(DOT_SIZE);
  logic [COORD_W-1:0] dot_x, dot_y, grad;
  logic [COORD_W:0] xe, ye, dxe, dye;
  lcd_mode_e mode_q;
  logic [2:0] bar;
  logic [7:0] grey;
  logic dot_hit, border_hit;
  logic [23:0] pat, pix;
  lcd_bounce_dot #(
    .LCD_WIDTH(LCD_WIDTH), .LCD_HEIGHT(LCD_HEIGHT), .COORD_W(COORD_W),
    .DOT_SIZE(DOT_SIZE), .STEP_DIV(STEP_DIV)
  ) u_dot (.CLK(CLK), .RSTN(RSTN), .PAUSE(PAUSE), .dot_x(dot_x), .dot_y(dot_y));
  // One extra bit keeps X+DOT_SIZE from wrapping; the dot side is added, never subtracted.
  assign xe  = {1'b0, X};
  assign ye  = {1'b0, Y};
  assign dxe = {1'b0, dot_x};
  assign dye = {1'b0, dot_y};
  assign dot_hit = (xe + DS >= dxe) && (xe <= dxe + DS) && (ye + DS >= dye) && (ye <= dye + DS);
  assign border_hit = X == '0 || X == COORD_W'(LCD_WIDTH - 1) || Y == '0 || Y == COORD_W'(LCD_HEIGHT - 1);
  always_comb begin
    bar = '0;
    for (int k = 1; k < NUM_BARS; k++)
      if (int'(X) >= k * LCD_WIDTH / NUM_BARS) bar = 3'(k);
  end
  assign grad = X >> GRAD_SHIFT;
  assign grey = (grad > COORD_W'(255)) ? 8'hFF : grad[7:0];
  assign pat = mode_q == LCD_MODE_BARS  ? LCD_PALETTE[bar] :
               mode_q == LCD_MODE_CHECK ? ((X[CHECK_LOG2] ^ Y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000) :
               mode_q == LCD_MODE_GRAD  ? {3{grey}} : SOLID_RGB;
  assign pix = (OVERLAY_EN && (border_hit || dot_hit)) ? 24'hFFFFFF : pat;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      {R, G, B} <= '0;
      DE_O      <= 1'b0;
      mode_q    <= LCD_MODE_BARS;
    end else begin
      if (FRAME_START) mode_q <= lcd_mode_e'(MODE);
      {R, G, B} <= DEN ? pix : 24'h000000;
      DE_O      <= DEN;
    end
endmodule
